// File: rtl/ex_stage.sv
// Execute stage: ALU ops, branch/jump redirect, JAL/JALR link, and LW/SW
// over a req/ack data-memory port with optional timeout abort.
// All result outputs are registered; the stage stalls decode while a memory
// access is outstanding.
module ex_stage #(
   parameter int XLEN        = 32,
   parameter int MEM_TIMEOUT = 255   // 0 = wait for ack forever
) (
   input  logic            clk,
   input  logic            rst,          // async, active low
   input  logic            ex_valid_i,
   output logic            ex_ready_o,
   input  logic [7:0]      aluop_i,
   input  logic [3:0]      alusel_i,
   input  logic [XLEN-1:0] reg1_i,
   input  logic [XLEN-1:0] reg2_i,
   input  logic [XLEN-1:0] imm_i,
   input  logic [4:0]      wd_i,
   input  logic [XLEN-1:0] pc_i,
   output logic            wreg_o,
   output logic [4:0]      wd_o,
   output logic [XLEN-1:0] wdata_o,
   output logic            branch_flag_o,
   output logic [XLEN-1:0] branch_target_o,
   output logic            mem_req_o,
   output logic            mem_we_o,
   output logic [XLEN-1:0] mem_addr_o,
   output logic [XLEN-1:0] mem_wdata_o,
   input  logic            mem_ack_i,
   input  logic [XLEN-1:0] mem_rdata_i,
   output logic            mem_err_o
);

   // ALU operation codes
   localparam logic [7:0] OP_ADD = 8'h20;
   localparam logic [7:0] OP_SUB = 8'h22;
   localparam logic [7:0] OP_AND = 8'h24;
   localparam logic [7:0] OP_OR  = 8'h25;
   localparam logic [7:0] OP_XOR = 8'h26;

   // Instruction classes
   localparam logic [3:0] SEL_NOP  = 4'd0;
   localparam logic [3:0] SEL_R    = 4'd1;
   localparam logic [3:0] SEL_I    = 4'd2;
   localparam logic [3:0] SEL_B    = 4'd3;
   localparam logic [3:0] SEL_NB   = 4'd4;
   localparam logic [3:0] SEL_LW   = 4'd5;
   localparam logic [3:0] SEL_SW   = 4'd6;
   localparam logic [3:0] SEL_JAL  = 4'd7;
   localparam logic [3:0] SEL_JALR = 4'd8;

   localparam logic [31:0] TO_LIM = MEM_TIMEOUT;

   typedef enum logic {IDLE, MEM} state_t;

   state_t state_q, state_d;

   logic            wreg_q, wreg_d;
   logic [4:0]      wd_q, wd_d;
   logic [XLEN-1:0] wdata_q, wdata_d;
   logic            br_q, br_d;
   logic [XLEN-1:0] tgt_q, tgt_d;
   logic            req_q, req_d;
   logic            we_q, we_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic [XLEN-1:0] mwdata_q, mwdata_d;
   logic            err_q, err_d;
   logic [4:0]      pwd_q, pwd_d;      // load destination held across MEM
   logic [31:0]     cnt_q, cnt_d;      // MEM cycles elapsed without ack

   logic            accept;
   logic            is_mem;
   logic            timeout_hit;
   logic [XLEN-1:0] alu_res;
   logic [XLEN-1:0] r1_imm;
   logic [XLEN-1:0] pc_imm;
   logic [31:0]     cnt_inc;

   assign accept      = ex_valid_i & (state_q == IDLE);
   assign is_mem      = (alusel_i == SEL_LW) | (alusel_i == SEL_SW);
   assign r1_imm      = reg1_i + imm_i;
   assign pc_imm      = pc_i + imm_i;
   assign cnt_inc     = cnt_q + 32'd1;
   assign timeout_hit = (TO_LIM != 32'd0) && (cnt_inc == TO_LIM);

   // ALU; I-type arrives with its immediate already on reg2_i
   always_comb begin
      case (aluop_i)
         OP_ADD:  alu_res = reg1_i + reg2_i;
         OP_SUB:  alu_res = reg1_i - reg2_i;
         OP_AND:  alu_res = reg1_i & reg2_i;
         OP_OR:   alu_res = reg1_i | reg2_i;
         OP_XOR:  alu_res = reg1_i ^ reg2_i;
         default: alu_res = '0;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // FSM next state: a memory op parks us in MEM until ack or abort
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (accept && is_mem)         state_d = MEM;
         MEM:  if (mem_ack_i || timeout_hit) state_d = IDLE;
         default:                            state_d = IDLE;
      endcase
   end

   // FSM outputs: ready is forced low while reset is held
   always_comb begin
      ex_ready_o = rst & (state_q == IDLE);
   end

   // Datapath next state; strobes default low, everything else holds
   always_comb begin
      wreg_d   = 1'b0;
      br_d     = 1'b0;
      err_d    = 1'b0;
      wd_d     = wd_q;
      wdata_d  = wdata_q;
      tgt_d    = tgt_q;
      req_d    = req_q;
      we_d     = we_q;
      addr_d   = addr_q;
      mwdata_d = mwdata_q;
      pwd_d    = pwd_q;
      cnt_d    = cnt_q;
      if (state_q == IDLE) begin
         if (accept) begin
            case (alusel_i)
               SEL_R, SEL_I: begin
                  wd_d    = wd_i;
                  wdata_d = alu_res;
                  wreg_d  = |wd_i;
               end
               SEL_B: begin
                  br_d  = 1'b1;
                  tgt_d = pc_imm;
               end
               SEL_JAL, SEL_JALR: begin
                  br_d    = 1'b1;
                  tgt_d   = (alusel_i == SEL_JAL) ? pc_imm : {r1_imm[XLEN-1:1], 1'b0};
                  wd_d    = wd_i;
                  wdata_d = pc_i + XLEN'(4);
                  wreg_d  = |wd_i;
               end
               SEL_LW, SEL_SW: begin
                  req_d    = 1'b1;
                  we_d     = (alusel_i == SEL_SW);
                  addr_d   = r1_imm;
                  mwdata_d = reg2_i;
                  pwd_d    = wd_i;
                  cnt_d    = '0;
               end
               default: ;  // NOP, NB and unknown classes: nothing to do
            endcase
         end
      end else begin
         if (mem_ack_i) begin
            req_d = 1'b0;
            if (!we_q) begin
               wd_d    = pwd_q;
               wdata_d = mem_rdata_i;
               wreg_d  = |pwd_q;
            end
         end else if (timeout_hit) begin
            req_d = 1'b0;
            err_d = 1'b1;
         end else begin
            cnt_d = cnt_inc;
         end
      end
   end

   // Datapath registers; reset clears the bus request asynchronously
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wreg_q   <= 1'b0;
         wd_q     <= '0;
         wdata_q  <= '0;
         br_q     <= 1'b0;
         tgt_q    <= '0;
         req_q    <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         mwdata_q <= '0;
         err_q    <= 1'b0;
         pwd_q    <= '0;
         cnt_q    <= '0;
      end else begin
         wreg_q   <= wreg_d;
         wd_q     <= wd_d;
         wdata_q  <= wdata_d;
         br_q     <= br_d;
         tgt_q    <= tgt_d;
         req_q    <= req_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         mwdata_q <= mwdata_d;
         err_q    <= err_d;
         pwd_q    <= pwd_d;
         cnt_q    <= cnt_d;
      end
   end

   assign wreg_o          = wreg_q;
   assign wd_o            = wd_q;
   assign wdata_o         = wdata_q;
   assign branch_flag_o   = br_q;
   assign branch_target_o = tgt_q;
   assign mem_req_o       = req_q;
   assign mem_we_o        = we_q;
   assign mem_addr_o      = addr_q;
   assign mem_wdata_o     = mwdata_q;
   assign mem_err_o       = err_q;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed cases with literal expectations, then random
// bundles and random memory latencies checked every cycle against a
// cycle-level behavioural model.
module tb_ex_stage;
   localparam int TO = 4;

   localparam logic [7:0] OP_ADD = 8'h20, OP_SUB = 8'h22, OP_AND = 8'h24,
                          OP_OR  = 8'h25, OP_XOR = 8'h26;
   localparam logic [3:0] S_NOP = 4'd0, S_R = 4'd1, S_I = 4'd2, S_B = 4'd3,
                          S_NB = 4'd4, S_LW = 4'd5, S_SW = 4'd6, S_JAL = 4'd7,
                          S_JALR = 4'd8;

   logic        clk = 1'b0, rst = 1'b0;
   logic        ex_valid_i = 1'b0, ex_ready_o;
   logic [7:0]  aluop_i = '0;
   logic [3:0]  alusel_i = '0;
   logic [31:0] reg1_i = '0, reg2_i = '0, imm_i = '0, pc_i = '0;
   logic [4:0]  wd_i = '0;
   logic        wreg_o, branch_flag_o, mem_req_o, mem_we_o, mem_err_o;
   logic [4:0]  wd_o;
   logic [31:0] wdata_o, branch_target_o, mem_addr_o, mem_wdata_o;
   logic        mem_ack_i = 1'b0;
   logic [31:0] mem_rdata_i = '0;

   always #5 clk = ~clk;

   ex_stage #(.XLEN(32), .MEM_TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
      .aluop_i(aluop_i), .alusel_i(alusel_i), .reg1_i(reg1_i), .reg2_i(reg2_i),
      .imm_i(imm_i), .wd_i(wd_i), .pc_i(pc_i), .wreg_o(wreg_o), .wd_o(wd_o),
      .wdata_o(wdata_o), .branch_flag_o(branch_flag_o),
      .branch_target_o(branch_target_o), .mem_req_o(mem_req_o),
      .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i), .mem_err_o(mem_err_o)
   );

   int n_chk = 0, n_fail = 0;

   // Behavioural model: expected outputs plus the outstanding access
   logic        e_wreg, e_br, e_err, e_req, e_we;
   logic [4:0]  e_wd, m_load_wd;
   logic [31:0] e_wdata, e_tgt, e_addr, e_mwd;
   logic        m_busy;
   int          m_waited;
   int          ack_dly, dly_next;
   logic        rd_fix_en;
   logic [31:0] rd_fix;

   function automatic logic [31:0] alu(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         OP_XOR:  return a ^ b;
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_reset();
      e_wreg = 0; e_br = 0; e_err = 0; e_req = 0; e_we = 0;
      e_wd = 0; m_load_wd = 0; e_wdata = 0; e_tgt = 0; e_addr = 0; e_mwd = 0;
      m_busy = 0; m_waited = 0; ack_dly = 0;
   endtask

   // What the stage must show after this clock edge, given the inputs at it
   task automatic model_step();
      if (!rst) begin
         model_reset();
         return;
      end
      e_wreg = 0; e_br = 0; e_err = 0;
      if (!m_busy) begin
         if (ex_valid_i) begin
            case (alusel_i)
               S_R, S_I: begin
                  e_wd = wd_i; e_wdata = alu(aluop_i, reg1_i, reg2_i); e_wreg = (wd_i != 0);
               end
               S_B: begin e_br = 1; e_tgt = pc_i + imm_i; end
               S_JAL: begin
                  e_br = 1; e_tgt = pc_i + imm_i;
                  e_wd = wd_i; e_wdata = pc_i + 4; e_wreg = (wd_i != 0);
               end
               S_JALR: begin
                  e_br = 1; e_tgt = (reg1_i + imm_i) & ~32'd1;
                  e_wd = wd_i; e_wdata = pc_i + 4; e_wreg = (wd_i != 0);
               end
               S_LW, S_SW: begin
                  m_busy = 1; m_waited = 0; e_req = 1;
                  e_we = (alusel_i == S_SW); e_addr = reg1_i + imm_i; e_mwd = reg2_i;
                  m_load_wd = wd_i;
                  ack_dly = (dly_next >= 0) ? dly_next : int'($urandom_range(0, 5));
                  dly_next = -1;
               end
               default: ;
            endcase
         end
      end else if (mem_ack_i) begin
         m_busy = 0; e_req = 0;
         if (!e_we) begin e_wd = m_load_wd; e_wdata = mem_rdata_i; e_wreg = (m_load_wd != 0); end
      end else begin
         m_waited++;
         if (TO != 0 && m_waited == TO) begin m_busy = 0; e_req = 0; e_err = 1; end
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      chk("wreg", wreg_o, e_wreg);
      chk("branch_flag", branch_flag_o, e_br);
      chk("mem_err", mem_err_o, e_err);
      chk("mem_req", mem_req_o, e_req);
      chk("ex_ready", ex_ready_o, rst && !m_busy);
      chk("wd", wd_o, e_wd);
      chk("wdata", wdata_o, e_wdata);
      if (e_br) chk("branch_target", branch_target_o, e_tgt);
      if (e_req) begin
         chk("mem_we", mem_we_o, e_we);
         chk("mem_addr", mem_addr_o, e_addr);
         chk("mem_wdata", mem_wdata_o, e_mwd);
      end
   endtask

   // One clock: drive memory side, take the edge, step model, compare
   task automatic tick();
      mem_ack_i = m_busy && (ack_dly == 0);
      if (m_busy && ack_dly > 0) ack_dly--;
      mem_rdata_i = rd_fix_en ? rd_fix : $urandom;
      @(posedge clk);
      model_step();
      #1;
      compare_all();
      @(negedge clk);
   endtask

   task automatic drive(input logic v, input logic [3:0] sel, input logic [7:0] op,
                        input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] imm,
                        input logic [4:0] wd, input logic [31:0] pc);
      ex_valid_i = v; alusel_i = sel; aluop_i = op;
      reg1_i = r1; reg2_i = r2; imm_i = imm; wd_i = wd; pc_i = pc;
   endtask

   initial begin
      model_reset();
      dly_next = -1; rd_fix_en = 0; rd_fix = 0;

      // reset holds every output low
      #2;
      chk("reset_ready", ex_ready_o, 0);
      chk("reset_wreg", wreg_o, 0);
      chk("reset_req", mem_req_o, 0);
      chk("reset_wdata", wdata_o, 0);
      chk("reset_err", mem_err_o, 0);
      @(negedge clk); @(negedge clk);
      rst = 1; #1;
      chk("release_ready", ex_ready_o, 1);
      @(negedge clk);

      // ADD 7+5 -> x3
      drive(1, S_R, OP_ADD, 7, 5, 0, 3, 0); tick();
      chk("add_wreg", wreg_o, 1); chk("add_wd", wd_o, 3); chk("add_wdata", wdata_o, 12);
      // SUB 0-1
      drive(1, S_R, OP_SUB, 0, 1, 0, 4, 0); tick();
      chk("sub_wdata", wdata_o, 32'hFFFF_FFFF);
      // taken branch
      drive(1, S_B, OP_ADD, 0, 0, 32'hFFFF_FFF8, 0, 32'h100); tick();
      chk("b_flag", branch_flag_o, 1); chk("b_target", branch_target_o, 32'hF8);
      chk("b_wreg", wreg_o, 0);
      // not-taken branch
      drive(1, S_NB, OP_ADD, 0, 0, 8, 5, 32'h100); tick();
      chk("nb_flag", branch_flag_o, 0);
      // JALR
      drive(1, S_JALR, OP_ADD, 32'h203, 0, 4, 1, 32'h300); tick();
      chk("jalr_target", branch_target_o, 32'h206); chk("jalr_link", wdata_o, 32'h304);
      chk("jalr_flag", branch_flag_o, 1);
      // valid low: strobes off, results held
      drive(0, S_R, OP_ADD, 1, 1, 0, 9, 0); tick();
      chk("idle_wreg", wreg_o, 0); chk("idle_wdata_hold", wdata_o, 32'h304);

      // LW with ack on the 4th MEM cycle (also the timeout limit: ack wins)
      rd_fix_en = 1; rd_fix = 32'hDEAD_BEEF; dly_next = 3;
      drive(1, S_LW, OP_ADD, 32'h40, 32'h55, 4, 7, 0); tick();
      drive(0, S_NOP, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         chk("lw_addr", mem_addr_o, 32'h44); chk("lw_we", mem_we_o, 0);
         chk("lw_ready", ex_ready_o, 0); chk("lw_req", mem_req_o, 1);
         tick();
      end
      tick();
      chk("lw_wreg", wreg_o, 1); chk("lw_wdata", wdata_o, 32'hDEAD_BEEF);
      chk("lw_no_err", mem_err_o, 0); chk("lw_req_drop", mem_req_o, 0);
      rd_fix_en = 0;

      // SW to x0, immediate ack
      dly_next = 0;
      drive(1, S_SW, OP_ADD, 32'h80, 32'h1234, 0, 0, 0); tick();
      drive(0, S_NOP, 0, 0, 0, 0, 0, 0);
      chk("sw_req", mem_req_o, 1); chk("sw_we", mem_we_o, 1);
      tick();
      chk("sw_req_drop", mem_req_o, 0); chk("sw_wreg", wreg_o, 0);
      chk("sw_ready", ex_ready_o, 1);

      // timeout: never acked
      dly_next = 1000;
      drive(1, S_LW, OP_ADD, 32'h10, 0, 0, 5, 0); tick();
      drive(0, S_NOP, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) tick();
      chk("to_err_early", mem_err_o, 0);
      tick();
      chk("to_err", mem_err_o, 1); chk("to_req", mem_req_o, 0); chk("to_wreg", wreg_o, 0);
      tick();
      chk("to_err_pulse", mem_err_o, 0);

      // reset in the middle of an access
      dly_next = 1000;
      drive(1, S_LW, OP_ADD, 32'h20, 0, 0, 6, 0); tick();
      drive(0, S_NOP, 0, 0, 0, 0, 0, 0); tick();
      rst = 0; #1;
      chk("rst_mid_req", mem_req_o, 0); chk("rst_mid_ready", ex_ready_o, 0);
      @(negedge clk);
      tick();
      rst = 1; #1;
      chk("rst_mid_release", ex_ready_o, 1);
      @(negedge clk);

      // random traffic
      for (int n = 0; n < 600; n++) begin
         logic [7:0] op;
         case ($urandom_range(0, 5))
            0: op = OP_ADD; 1: op = OP_SUB; 2: op = OP_AND;
            3: op = OP_OR;  4: op = OP_XOR; default: op = 8'($urandom);
         endcase
         drive(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 8)), op,
               $urandom, $urandom, $urandom, 5'($urandom), $urandom);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end
endmodule
